// File: rtl/mac_pkg.sv
// Shared types and helpers for the MAC output drain path.
// Default sizes, drain FSM state encoding and the (DW+1)->DW saturating narrow.
package mac_pkg;

  localparam int DW_DEF   = 32;
  localparam int POX_DEF  = 3;
  localparam int SAT_MAXW = 64;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } drain_state_t;

  // Clamp a (w+1)-bit signed value, held in the low bits of s, to w bits.
  // Overflow exists exactly when the two top bits of the sum disagree.
  function automatic logic [SAT_MAXW-1:0] sat_narrow(input logic [SAT_MAXW:0] s,
                                                     input logic [6:0]        w);
    logic [SAT_MAXW-1:0] lim;
    logic [SAT_MAXW-1:0] r;
    lim = 64'd1 << (w - 7'd1);
    r   = s[SAT_MAXW-1:0];
    if (s[w] != s[w - 7'd1]) begin
      r = s[w] ? lim : (lim - 64'd1);
    end
    return r;
  endfunction

endpackage

// File: rtl/mac_postproc.sv
// Per-lane post-processing: bias add, narrowing to DW bits, optional ReLU.
// MAC_DRAIN_SAT_EN selects saturation instead of two's-complement wrap.
module mac_postproc
  import mac_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic [DW-1:0] i_result,
  input  logic [DW-1:0] i_bias,
  input  logic          i_relu_en,
  output logic [DW-1:0] o_word
);

  logic [DW-1:0] w_nar;

`ifdef MAC_DRAIN_SAT_EN
  logic [DW:0]         w_sum;
  logic [SAT_MAXW-1:0] w_sat;

  assign w_sum = {i_result[DW-1], i_result} + {i_bias[DW-1], i_bias};
  assign w_sat = sat_narrow({{(SAT_MAXW-DW){w_sum[DW]}}, w_sum}, 7'(DW));
  assign w_nar = w_sat[DW-1:0];
`else
  // Low DW bits of the wide sum are the plain DW-bit wrapping add.
  assign w_nar = i_result + i_bias;
`endif

  assign o_word = (i_relu_en && w_nar[DW-1]) ? '0 : w_nar;

endmodule

// File: rtl/mac_drain.sv
// Output drain stage for the POX-lane MAC bank: capture, one-deep hold, streamed drain.
// Build option MAC_DRAIN_SAT_EN: saturate bias-added results instead of wrapping.
//
//   state | meaning
//   IDLE  | drain bank empty, waiting for the hold bank to fill
//   DRAIN | streaming drain[idx] to the output buffer
module mac_drain
  import mac_pkg::*;
#(
  parameter  int DW  = DW_DEF,
  parameter  int POX = POX_DEF,
  localparam int IW  = $clog2(POX)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [DW-1:0]  result [POX],
  input  logic [POX-1:0] cnt_c,
  input  logic [DW-1:0]  bias,
  input  logic           relu_en,
  output logic           mac_ena,
  output logic [DW-1:0]  out_data,
  output logic [IW-1:0]  out_idx,
  output logic           out_last,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           busy,
  output logic           ovf_err,
  output logic           lane_err
);

  localparam logic [IW-1:0] LAST_IDX = IW'(POX - 1);

  drain_state_t  r_state;
  logic [IW-1:0] r_idx;
  logic          r_hold_full;
  logic [DW-1:0] r_hold  [POX];
  logic [DW-1:0] r_drain [POX];
  logic [DW-1:0] r_out_data;
  logic [IW-1:0] r_out_idx;
  logic          r_out_last;
  logic          r_out_valid;
  logic          r_ovf_err;
  logic          r_lane_err;

  logic [DW-1:0] w_pp [POX];
  logic          w_capture;
  logic          w_lane_mis;
  logic          w_fire;
  logic          w_at_last;
  logic          w_load;
  logic [IW-1:0] w_idx_nxt;

  for (genvar g = 0; g < POX; g++) begin : g_lane
    mac_postproc #(.DW(DW)) u_pp (
      .i_result  (result[g]),
      .i_bias    (bias),
      .i_relu_en (relu_en),
      .o_word    (w_pp[g])
    );
  end

  assign w_capture  = &cnt_c;
  assign w_lane_mis = (|cnt_c) && !w_capture;
  assign w_fire     = r_out_valid && out_ready;
  assign w_at_last  = (r_idx == LAST_IDX);
  assign w_idx_nxt  = r_idx + 1'b1;
  // Hold moves to drain when drain is empty or its last word leaves this cycle.
  assign w_load     = r_hold_full && ((r_state == IDLE) || (w_fire && w_at_last));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_full <= 1'b0;
      r_ovf_err   <= 1'b0;
      r_lane_err  <= 1'b0;
      for (int i = 0; i < POX; i++) r_hold[i] <= '0;
    end else begin
      if (w_capture && (!r_hold_full || w_load)) begin
        r_hold      <= w_pp;
        r_hold_full <= 1'b1;
      end else if (w_load) begin
        r_hold_full <= 1'b0;
      end
      if (w_capture && r_hold_full && !w_load) r_ovf_err <= 1'b1;
      if (w_lane_mis) r_lane_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_idx   <= '0;
      r_out_last  <= 1'b0;
      for (int i = 0; i < POX; i++) r_drain[i] <= '0;
    end else if (w_load) begin
      r_state     <= DRAIN;
      r_drain     <= r_hold;
      r_idx       <= '0;
      r_out_valid <= 1'b1;
      r_out_data  <= r_hold[0];
      r_out_idx   <= '0;
      r_out_last  <= 1'b0;
    end else if ((r_state == DRAIN) && w_fire) begin
      if (!w_at_last) begin
        r_idx      <= w_idx_nxt;
        r_out_idx  <= w_idx_nxt;
        r_out_data <= r_drain[w_idx_nxt];
        r_out_last <= (w_idx_nxt == LAST_IDX);
      end else begin
        r_state     <= IDLE;
        r_idx       <= '0;
        r_out_valid <= 1'b0;
        r_out_data  <= '0;
        r_out_idx   <= '0;
        r_out_last  <= 1'b0;
      end
    end
  end

  assign mac_ena   = !r_hold_full;
  assign busy      = r_hold_full || (r_state == DRAIN);
  assign out_data  = r_out_data;
  assign out_idx   = r_out_idx;
  assign out_last  = r_out_last;
  assign out_valid = r_out_valid;
  assign ovf_err   = r_ovf_err;
  assign lane_err  = r_lane_err;

endmodule

// File: tb/tb_mac_drain.sv
// Directed bench for mac_drain (DW=32, POX=3) with hand-computed expected words.
module tb_mac_drain;

  localparam int DW  = 32;
  localparam int POX = 3;
  localparam int IW  = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [DW-1:0]  result [POX];
  logic [POX-1:0] cnt_c;
  logic [DW-1:0]  bias;
  logic           relu_en;
  logic           mac_ena;
  logic [DW-1:0]  out_data;
  logic [IW-1:0]  out_idx;
  logic           out_last;
  logic           out_valid;
  logic           out_ready;
  logic           busy;
  logic           ovf_err;
  logic           lane_err;

  int n_chk  = 0;
  int n_pass = 0;
  logic [DW-1:0] exp_w [$];

  always #5 clk = ~clk;

  mac_drain #(.DW(DW), .POX(POX)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .result    (result),
    .cnt_c     (cnt_c),
    .bias      (bias),
    .relu_en   (relu_en),
    .mac_ena   (mac_ena),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .ovf_err   (ovf_err),
    .lane_err  (lane_err)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic complete(input logic [DW-1:0] r0, input logic [DW-1:0] r1,
                          input logic [DW-1:0] r2, input logic [DW-1:0] b,
                          input logic re);
    result[0] = r0;
    result[1] = r1;
    result[2] = r2;
    bias      = b;
    relu_en   = re;
    cnt_c     = '1;
    cyc();
    cnt_c     = '0;
  endtask

  task automatic beat(input string tag, input logic [DW-1:0] d, input int idx, input logic last);
    chk({tag, " valid"}, 64'(out_valid), 64'd1);
    chk({tag, " data"},  64'(out_data),  64'(d));
    chk({tag, " idx"},   64'(out_idx),   64'(idx));
    chk({tag, " last"},  64'(out_last),  64'(last));
  endtask

  // Streams exp_w with ready high; every beat after the first must follow with no gap.
  task automatic drain_n(input string tag);
    int n;
    int waited;
    n = exp_w.size();
    waited = 0;
    out_ready = 1'b1;
    while (!out_valid && waited < 20) begin
      cyc();
      waited++;
    end
    for (int i = 0; i < n; i++) begin
      beat($sformatf("%s b%0d", tag, i), exp_w[i], i % POX, (i % POX) == POX - 1);
      cyc();
    end
    chk({tag, " end valid"}, 64'(out_valid), 64'd0);
    exp_w.delete();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " valid"},    64'(out_valid), 64'd0);
    chk({tag, " data"},     64'(out_data),  64'd0);
    chk({tag, " idx"},      64'(out_idx),   64'd0);
    chk({tag, " last"},     64'(out_last),  64'd0);
    chk({tag, " mac_ena"},  64'(mac_ena),   64'd1);
    chk({tag, " busy"},     64'(busy),      64'd0);
    chk({tag, " ovf_err"},  64'(ovf_err),   64'd0);
    chk({tag, " lane_err"}, 64'(lane_err),  64'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    cnt_c     = '0;
    bias      = '0;
    relu_en   = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < POX; i++) result[i] = '0;
    repeat (3) cyc();
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    cyc();

    // Single group, cycle-exact latency
    out_ready = 1'b1;
    complete(10, -5, 7, 2, 1'b0);
    chk("t1 mac_ena T+1", 64'(mac_ena),   64'd0);
    chk("t1 valid T+1",   64'(out_valid), 64'd0);
    chk("t1 busy T+1",    64'(busy),      64'd1);
    cyc();
    beat("t1 b0", 32'd12, 0, 1'b0);
    cyc();
    beat("t1 b1", -32'sd3, 1, 1'b0);
    cyc();
    beat("t1 b2", 32'd9, 2, 1'b1);
    cyc();
    chk("t1 end valid",   64'(out_valid), 64'd0);
    chk("t1 end busy",    64'(busy),      64'd0);
    chk("t1 end mac_ena", 64'(mac_ena),   64'd1);

    // ReLU with backpressure on beat 0
    out_ready = 1'b0;
    complete(-20, 4, 0, 1, 1'b1);
    cyc();
    for (int k = 0; k < 3; k++) begin
      beat($sformatf("t2 stall%0d", k), 32'd0, 0, 1'b0);
      cyc();
    end
    out_ready = 1'b1;
    beat("t2 b0", 32'd0, 0, 1'b0);
    cyc();
    beat("t2 b1", 32'd5, 1, 1'b0);
    cyc();
    beat("t2 b2", 32'd1, 2, 1'b1);
    cyc();
    chk("t2 end valid", 64'(out_valid), 64'd0);

    // Narrowing: positive overflow, then negative overflow followed by ReLU
    complete(32'h7FFF_FFFF, 32'h7FFF_FFFE, -3, 1, 1'b0);
`ifdef MAC_DRAIN_SAT_EN
    exp_w.push_back(32'h7FFF_FFFF);
`else
    exp_w.push_back(32'h8000_0000);
`endif
    exp_w.push_back(32'h7FFF_FFFF);
    exp_w.push_back(32'hFFFF_FFFE);
    drain_n("sat_pos");

    complete(32'h8000_0000, 32'h8000_0001, 0, -2, 1'b1);
`ifdef MAC_DRAIN_SAT_EN
    exp_w.push_back(32'h0);
    exp_w.push_back(32'h0);
`else
    exp_w.push_back(32'h7FFF_FFFE);
    exp_w.push_back(32'h7FFF_FFFF);
`endif
    exp_w.push_back(32'h0);
    drain_n("sat_relu");

    // Back-to-back groups and overflow
    out_ready = 1'b0;
    complete(1, 2, 3, 0, 1'b0);
    chk("b2b mac_ena A",   64'(mac_ena),   64'd0);
    cyc();
    chk("b2b mac_ena mv",  64'(mac_ena),   64'd1);
    chk("b2b valid mv",    64'(out_valid), 64'd1);
    complete(100, 200, 300, 10, 1'b0);
    chk("b2b mac_ena B",   64'(mac_ena),   64'd0);
    chk("b2b ovf B",       64'(ovf_err),   64'd0);
    complete(7, 7, 7, 0, 1'b0);
    chk("b2b ovf C",       64'(ovf_err),   64'd1);
    chk("b2b mac_ena C",   64'(mac_ena),   64'd0);
    chk("b2b data held",   64'(out_data),  64'd1);
    exp_w.push_back(32'd1);
    exp_w.push_back(32'd2);
    exp_w.push_back(32'd3);
    exp_w.push_back(32'd110);
    exp_w.push_back(32'd210);
    exp_w.push_back(32'd310);
    drain_n("b2b");
    chk("b2b end mac_ena", 64'(mac_ena),   64'd1);

    // Lane mismatch
    cnt_c = 3'b101;
    cyc();
    cnt_c = '0;
    chk("lane lane_err", 64'(lane_err), 64'd1);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("lane valid%0d", k), 64'(out_valid), 64'd0);
      chk($sformatf("lane busy%0d", k),  64'(busy),      64'd0);
      cyc();
    end
    chk("lane ovf sticky", 64'(ovf_err), 64'd1);

    // Reset mid-drain
    out_ready = 1'b1;
    complete(5, 6, 7, 0, 1'b0);
    cyc();
    beat("rst b0", 32'd5, 0, 1'b0);
    cyc();
    beat("rst b1", 32'd6, 1, 1'b0);
    cyc();
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("mid rst");
    cyc();
    rst_n = 1'b1;
    cyc();
    complete(20, 30, 40, 1, 1'b0);
    exp_w.push_back(32'd21);
    exp_w.push_back(32'd31);
    exp_w.push_back(32'd41);
    drain_n("post_rst");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
